// File: rtl/smart_mac_pkg.sv
// Shared types and helpers for the multi-lane smart MAC processing element.
// Holds the mode encodings, the drain state enum, the saturating narrow
// function used on drain, and the lane slice offset helper.
package smart_mac_pkg;

    typedef enum logic [1:0] {
        MODE_BYPASS = 2'b00,
        MODE_OS     = 2'b01,
        MODE_WS     = 2'b10,
        MODE_RSVD   = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        DRAIN = 2'b01,
        DONE  = 2'b10
    } drain_state_e;

    // Working width of the saturation helper; accumulators up to this width are supported.
    localparam int unsigned SAT_W = 64;

    // Clamp a signed value into the signed range of a w-bit word (result still SAT_W wide).
    function automatic logic signed [SAT_W-1:0] sat_word(input logic signed [SAT_W-1:0] x,
                                                         input int unsigned            w);
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        hi = (SAT_W'(1) <<< (w - 1)) - SAT_W'(1);
        lo = -hi - SAT_W'(1);
        if (x > hi) begin
            return hi;
        end
        if (x < lo) begin
            return lo;
        end
        return x;
    endfunction

    // Bit offset of lane k inside a lane-packed bus of w-bit words.
    function automatic int unsigned lane_lsb(input int unsigned k, input int unsigned w);
        return k * w;
    endfunction

endpackage

// File: rtl/mac_lane.sv
// One MAC lane: forwards its activation/top words, holds the WS weight and
// partial-sum result, and keeps the OS accumulator.
// Ports:
//   clk, rst          clock, synchronous active-low reset
//   mode              effective operating mode for this cycle
//   acc_en            accumulation allowed (low while draining)
//   clear             zero the accumulator (wins over accumulation)
//   load_w            latch top as the WS weight
//   both_valid        left and top are both valid
//   left, top         lane operands
//   right, bottom     registered forwards / WS partial sum
//   acc               registered accumulator
module mac_lane
    import smart_mac_pkg::*;
#(
    parameter int unsigned WORD_SIZE = 16,
    parameter int unsigned ACC_SIZE  = 2 * WORD_SIZE + 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  mode_e                      mode,
    input  logic                       acc_en,
    input  logic                       clear,
    input  logic                       load_w,
    input  logic                       both_valid,
    input  logic [WORD_SIZE-1:0]       left,
    input  logic [WORD_SIZE-1:0]       top,
    output logic [WORD_SIZE-1:0]       right,
    output logic [WORD_SIZE-1:0]       bottom,
    output logic signed [ACC_SIZE-1:0] acc
);

    localparam int unsigned PROD_W = 2 * WORD_SIZE;

    logic [WORD_SIZE-1:0]     w_q;
    logic signed [PROD_W-1:0] os_prod;
    logic [WORD_SIZE-1:0]     ws_sum;

    // Full-width signed product for OS accumulation.
    assign os_prod = PROD_W'($signed(left)) * PROD_W'($signed(top));
    // WS result only keeps the low word, which is sign-agnostic.
    assign ws_sum  = top + left * w_q;

    // Lane registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            right  <= '0;
            bottom <= '0;
            w_q    <= '0;
            acc    <= '0;
        end else begin
            right <= left;
            if (mode == MODE_WS) begin
                if (load_w) begin
                    w_q <= top;
                end else if (both_valid) begin
                    bottom <= ws_sum;
                end
            end else begin
                bottom <= top;
            end
            if (clear) begin
                acc <= '0;
            end else if (acc_en && (mode == MODE_OS) && both_valid) begin
                acc <= acc + ACC_SIZE'(os_prod);
            end
        end
    end

endmodule

// File: rtl/smart_mac_lanes.sv
// Multi-lane smart MAC processing element: LANES MAC lanes sharing one
// smart-bus attachment, with a handshaked drain FSM that serialises the
// saturated lane accumulators onto the vertical smart bus.
// Ports:
//   clk, rst                          clock, synchronous active-low reset
//   mode_in, clear_acc_in, load_w_in  control, honoured only while idle
//   drain_req_in                      start a drain (OS mode only)
//   left_in/left_valid_in             lane-packed activations
//   top_in/top_valid_in               lane-packed weights / partial sums
//   right_out/right_valid_out         registered left forward
//   bottom_out/bottom_valid_out       registered top forward or WS partial sum
//   select_*_out_smart                smart-bus source selects
//   *_smart_bus_in/out                horizontal and vertical smart buses
//   drain_valid_out/drain_ready_in    drain handshake
//   drain_busy_out, drain_done_out    drain status
module smart_mac_lanes
    import smart_mac_pkg::*;
#(
    parameter int unsigned WORD_SIZE  = 16,
    parameter int unsigned LANES      = 2,
    parameter int unsigned ACC_SIZE   = 2 * WORD_SIZE + 8,
    parameter int unsigned FRAC_SHIFT = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [1:0]                   mode_in,
    input  logic                         clear_acc_in,
    input  logic                         load_w_in,
    input  logic                         drain_req_in,
    input  logic [LANES*WORD_SIZE-1:0]   left_in,
    input  logic                         left_valid_in,
    input  logic [LANES*WORD_SIZE-1:0]   top_in,
    input  logic                         top_valid_in,
    output logic [LANES*WORD_SIZE-1:0]   right_out,
    output logic                         right_valid_out,
    output logic [LANES*WORD_SIZE-1:0]   bottom_out,
    output logic                         bottom_valid_out,
    input  logic                         select_right_out_smart,
    input  logic                         select_bottom_out_smart,
    input  logic [WORD_SIZE-1:0]         horizontal_smart_bus_in,
    input  logic [WORD_SIZE-1:0]         vertical_smart_bus_in,
    output logic [WORD_SIZE-1:0]         horizontal_smart_bus_out,
    output logic [WORD_SIZE-1:0]         vertical_smart_bus_out,
    output logic                         drain_valid_out,
    input  logic                         drain_ready_in,
    output logic                         drain_busy_out,
    output logic                         drain_done_out
);

    localparam int unsigned IDX_W = (LANES > 1) ? $clog2(LANES) : 1;

    drain_state_e                state_q;
    drain_state_e                state_d;
    logic [IDX_W-1:0]            idx_q;
    logic [IDX_W-1:0]            idx_d;

    logic                        in_idle;
    mode_e                       eff_mode;
    logic                        both_valid;
    logic                        lane_clear;
    logic                        lane_load_w;
    logic signed [ACC_SIZE-1:0]  lane_acc [LANES];
    logic signed [ACC_SIZE-1:0]  acc_shift;
    logic [WORD_SIZE-1:0]        drain_word;

    // Controls are only honoured in IDLE; a drain always starts from OS, so OS
    // stays the forwarding mode while draining.
    assign in_idle     = (state_q == IDLE);
    assign eff_mode    = in_idle ? mode_e'(mode_in) : MODE_OS;
    assign both_valid  = left_valid_in & top_valid_in;
    assign lane_clear  = (in_idle & clear_acc_in) | (state_q == DONE);
    assign lane_load_w = in_idle & load_w_in;

    // Lane array.
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        mac_lane #(
            .WORD_SIZE (WORD_SIZE),
            .ACC_SIZE  (ACC_SIZE)
        ) u_lane (
            .clk        (clk),
            .rst        (rst),
            .mode       (eff_mode),
            .acc_en     (in_idle),
            .clear      (lane_clear),
            .load_w     (lane_load_w),
            .both_valid (both_valid),
            .left       (left_in[lane_lsb(k, WORD_SIZE) +: WORD_SIZE]),
            .top        (top_in[lane_lsb(k, WORD_SIZE) +: WORD_SIZE]),
            .right      (right_out[lane_lsb(k, WORD_SIZE) +: WORD_SIZE]),
            .bottom     (bottom_out[lane_lsb(k, WORD_SIZE) +: WORD_SIZE]),
            .acc        (lane_acc[k])
        );
    end

    // Shared valid registers; a WS weight load suppresses the result valid.
    always_ff @(posedge clk) begin
        if (!rst) begin
            right_valid_out  <= 1'b0;
            bottom_valid_out <= 1'b0;
        end else begin
            right_valid_out <= left_valid_in;
            if (eff_mode == MODE_WS) begin
                bottom_valid_out <= both_valid & ~lane_load_w;
            end else begin
                bottom_valid_out <= top_valid_in;
            end
        end
    end

    // Drain state register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Drain next-state and status outputs.
    always_comb begin
        state_d         = state_q;
        idx_d           = idx_q;
        drain_valid_out = 1'b0;
        drain_busy_out  = 1'b0;
        drain_done_out  = 1'b0;
        case (state_q)
            IDLE: begin
                if (drain_req_in && (mode_e'(mode_in) == MODE_OS)) begin
                    state_d = DRAIN;
                    idx_d   = '0;
                end
            end
            DRAIN: begin
                drain_valid_out = 1'b1;
                drain_busy_out  = 1'b1;
                if (drain_ready_in) begin
                    if (idx_q == IDX_W'(LANES - 1)) begin
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            DONE: begin
                drain_busy_out = 1'b1;
                drain_done_out = 1'b1;
                state_d        = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Drained word: scaled and saturated accumulator of the current lane.
    assign acc_shift  = lane_acc[idx_q] >>> FRAC_SHIFT;
    assign drain_word = WORD_SIZE'(sat_word(SAT_W'(acc_shift), WORD_SIZE));

    // Smart-bus muxes; drain ownership overrides the vertical select.
    assign horizontal_smart_bus_out = select_right_out_smart ? right_out[WORD_SIZE-1:0]
                                                             : horizontal_smart_bus_in;
    assign vertical_smart_bus_out   = (state_q == DRAIN)       ? drain_word :
                                      select_bottom_out_smart  ? bottom_out[WORD_SIZE-1:0]
                                                               : vertical_smart_bus_in;

endmodule
